// File: rtl/aes_key_loader.sv
// aes_key_loader
//   Collects an AES cipher key as a stream of 32-bit words, assembles Nk words
//   in a shadow buffer, commits the whole key atomically onto keyOut, then
//   counts the downstream key-expansion settle time before raising keysValid.
//
// Parameters
//   Nk     : words per key (4/6/8)
//   Nr     : expansion rounds (10/12/14)
//   SETTLE : cycles from commit until every downstream round key is stable (>= 1)
//
// Ports
//   clk       : rising-edge clock
//   rst       : synchronous reset, active high, priority over all inputs
//   wordIn    : key word, most significant word first
//   wordValid : wordIn valid this cycle
//   wordReady : loader accepts a word this cycle
//   keyOut    : committed key, word 0 in bits [Nk*32-1 -: 32]
//   keysValid : round keys derived from keyOut are settled downstream
//   busy      : high while waiting for the expansion stage to settle
//   abort     : clears a partial load (only with KEYLOAD_ABORT_EN defined)
//
// Optional feature macro: KEYLOAD_ABORT_EN
module aes_key_loader #(
  parameter int unsigned Nk     = 4,
  parameter int unsigned Nr     = 10,
  parameter int unsigned SETTLE = Nr
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [31:0]       wordIn,
  input  logic              wordValid,
  output logic              wordReady,
  output logic [Nk*32-1:0]  keyOut,
  output logic              keysValid,
  output logic              busy
`ifdef KEYLOAD_ABORT_EN
  ,
  input  logic              abort
`endif
);

  localparam int unsigned KeyW   = Nk * 32;
  localparam int unsigned CntW   = $clog2(Nk) + 1;
  localparam int unsigned SetW   = $clog2(SETTLE + 1);

  typedef enum logic [1:0] {
    StLoad,
    StSettle,
    StValid
  } state_e;

  state_e            state_q, state_d;
  logic [CntW-1:0]   word_count_q, word_count_d;
  logic [31:0]       shadow_q [Nk];
  logic [31:0]       shadow_d [Nk];
  logic [KeyW-1:0]   key_q, key_d;
  logic              keys_valid_q, keys_valid_d;
  logic [SetW-1:0]   settle_cnt_q, settle_cnt_d;

  logic              abort_req;
  logic              ready;
  logic              accept;
  logic              last_word;
  logic [KeyW-1:0]   commit_key;

`ifdef KEYLOAD_ABORT_EN
  assign abort_req = abort;
`else
  assign abort_req = 1'b0;
`endif

  // Abort masks ready so a word presented alongside it is never consumed.
  assign ready     = (state_q != StSettle) && !abort_req;
  assign accept    = wordValid && ready;
  assign last_word = (word_count_q == CntW'(Nk - 1));

  // The final word bypasses the shadow so the key lands whole on the commit edge.
  always_comb begin
    commit_key = '0;
    for (int unsigned i = 0; i < Nk - 1; i++) begin
      commit_key[KeyW - 1 - i * 32 -: 32] = shadow_q[i];
    end
    commit_key[31:0] = wordIn;
  end

  always_comb begin
    state_d      = state_q;
    word_count_d = word_count_q;
    shadow_d     = shadow_q;
    key_d        = key_q;
    keys_valid_d = keys_valid_q;
    settle_cnt_d = settle_cnt_q;

    unique case (state_q)
      StLoad, StValid: begin
        if (abort_req) begin
          word_count_d = '0;
          for (int unsigned i = 0; i < Nk; i++) begin
            shadow_d[i] = '0;
          end
        end else if (accept) begin
          for (int unsigned i = 0; i < Nk; i++) begin
            if (word_count_q == CntW'(i)) begin
              shadow_d[i] = wordIn;
            end
          end
          if (last_word) begin
            word_count_d = '0;
            key_d        = commit_key;
            keys_valid_d = 1'b0;
            settle_cnt_d = SetW'(SETTLE - 1);
            state_d      = StSettle;
          end else begin
            word_count_d = word_count_q + 1'b1;
          end
        end
      end

      StSettle: begin
        if (settle_cnt_q == '0) begin
          keys_valid_d = 1'b1;
          state_d      = StValid;
        end else begin
          settle_cnt_d = settle_cnt_q - 1'b1;
        end
      end

      default: begin
        state_d = StLoad;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StLoad;
      word_count_q <= '0;
      key_q        <= '0;
      keys_valid_q <= 1'b0;
      settle_cnt_q <= '0;
      for (int unsigned i = 0; i < Nk; i++) begin
        shadow_q[i] <= '0;
      end
    end else begin
      state_q      <= state_d;
      word_count_q <= word_count_d;
      key_q        <= key_d;
      keys_valid_q <= keys_valid_d;
      settle_cnt_q <= settle_cnt_d;
      for (int unsigned i = 0; i < Nk; i++) begin
        shadow_q[i] <= shadow_d[i];
      end
    end
  end

  assign wordReady = ready;
  assign keyOut    = key_q;
  assign keysValid = keys_valid_q;
  assign busy      = (state_q == StSettle);

endmodule

// File: tb/tb_aes_key_loader.sv
// Testbench for aes_key_loader: directed steps plus randomized traffic, all
// compared against a word-queue reference model each cycle.
module tb_aes_key_loader;

  localparam int unsigned Nk     = 4;
  localparam int unsigned SETTLE = 10;
  localparam int unsigned KW     = Nk * 32;
`ifdef KEYLOAD_ABORT_EN
  localparam bit HasAbort = 1'b1;
`else
  localparam bit HasAbort = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic [31:0]   wordIn;
  logic          wordValid;
  logic          wordReady;
  logic [KW-1:0] keyOut;
  logic          keysValid;
  logic          busy;
  logic          abort;

  aes_key_loader #(
    .Nk     (Nk),
    .Nr     (10),
    .SETTLE (SETTLE)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .wordIn    (wordIn),
    .wordValid (wordValid),
    .wordReady (wordReady),
    .keyOut    (keyOut),
    .keysValid (keysValid),
    .busy      (busy)
`ifdef KEYLOAD_ABORT_EN
    ,
    .abort     (abort)
`endif
  );

  always #5 clk = ~clk;

  // Reference model: words accepted so far, committed key, settle edges left.
  logic [31:0]   m_q [$];
  logic [KW-1:0] m_key;
  bit            m_kv;
  int            m_left;
  int            n_checks;
  int            n_fails;

  task automatic check(input string tag, input logic [KW-1:0] obs, input logic [KW-1:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock cycle: drive, check ready, advance model on the edge, check outputs.
  task automatic step(input bit v, input logic [31:0] w, input bit r, input bit ab);
    bit ab_eff;
    bit m_ready;
    bit acc;
    rst       = r;
    wordValid = v;
    wordIn    = w;
    abort     = ab;
    #1;
    ab_eff  = HasAbort && ab;
    m_ready = (m_left == 0) && !ab_eff;
    if (!r) check("wordReady", KW'(wordReady), KW'(m_ready));
    acc = v && m_ready;
    @(posedge clk);
    if (r) begin
      m_q.delete();
      m_key  = '0;
      m_kv   = 1'b0;
      m_left = 0;
    end else if (m_left > 0) begin
      m_left--;
      if (m_left == 0) m_kv = 1'b1;
    end else if (ab_eff) begin
      m_q.delete();
    end else if (acc) begin
      m_q.push_back(w);
      if (m_q.size() == Nk) begin
        m_key = '0;
        foreach (m_q[i]) m_key = {m_key[KW-33:0], m_q[i]};
        m_q.delete();
        m_kv   = 1'b0;
        m_left = SETTLE;
      end
    end
    @(negedge clk);
    check("keyOut", keyOut, m_key);
    check("keysValid", KW'(keysValid), KW'(m_kv));
    check("busy", KW'(busy), KW'(m_left > 0));
  endtask

  initial begin
    logic [31:0]   fips [4];
    logic [31:0]   seq  [4];
    logic [31:0]   rk   [4];
    logic [KW-1:0] fips_key;
    logic [KW-1:0] seq_key;
    logic [KW-1:0] rk_key;
    int            rise_at;
    int            gaps [3];

    fips = '{32'h2b7e1516, 32'h28aed2a6, 32'habf71588, 32'h09cf4f3c};
    seq  = '{32'h00010203, 32'h04050607, 32'h08090a0b, 32'h0c0d0e0f};
    gaps = '{0, 1, 3};
    fips_key = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    seq_key  = 128'h000102030405060708090a0b0c0d0e0f;
    n_checks = 0;
    n_fails  = 0;
    m_key    = '0;
    m_kv     = 1'b0;
    m_left   = 0;
    rst = 1'b1; wordValid = 1'b0; wordIn = '0; abort = 1'b0;

    @(negedge clk);
    step(1'b0, 32'h0, 1'b1, 1'b0);
    step(1'b0, 32'h0, 1'b1, 1'b0);
    check("reset_keyOut", keyOut, '0);
    check("reset_keysValid", KW'(keysValid), '0);
    step(1'b0, 32'h0, 1'b0, 1'b0);

    // Known FIPS-197 key, back to back.
    for (int i = 0; i < 4; i++) step(1'b1, fips[i], 1'b0, 1'b0);
    check("fips_commit_key", keyOut, fips_key);
    check("fips_busy", KW'(busy), KW'(1'b1));
    check("fips_ready_low", KW'(wordReady), '0);

    // Words offered during settle must be ignored.
    for (int i = 0; i < SETTLE; i++) step(1'b1, 32'hdeadbeef, 1'b0, 1'b0);
    check("fips_keys_valid", KW'(keysValid), KW'(1'b1));
    check("settle_key_held", keyOut, fips_key);

    // New key loaded over a valid one.
    for (int i = 0; i < 3; i++) step(1'b1, seq[i], 1'b0, 1'b0);
    check("partial_keeps_valid", KW'(keysValid), KW'(1'b1));
    check("partial_keeps_key", keyOut, fips_key);
    step(1'b1, seq[3], 1'b0, 1'b0);
    check("seq_commit_key", keyOut, seq_key);
    check("seq_valid_drop", KW'(keysValid), '0);
    for (int i = 0; i < SETTLE; i++) step(1'b0, 32'h0, 1'b0, 1'b0);

    // Reset mid-load discards partial words.
    step(1'b1, $urandom, 1'b0, 1'b0);
    step(1'b1, $urandom, 1'b0, 1'b0);
    step(1'b1, $urandom, 1'b1, 1'b0);
    check("midload_rst_key", keyOut, '0);
    check("midload_rst_ready", KW'(wordReady), KW'(1'b1));
    for (int i = 0; i < 4; i++) rk[i] = $urandom;
    rk_key = {rk[0], rk[1], rk[2], rk[3]};
    for (int i = 0; i < 4; i++) step(1'b1, rk[i], 1'b0, 1'b0);
    check("post_rst_key", keyOut, rk_key);
    for (int i = 0; i < SETTLE; i++) step(1'b0, 32'h0, 1'b0, 1'b0);

    // Gaps between words change neither the key nor the settle latency.
    for (int g = 0; g < 3; g++) begin
      for (int i = 0; i < 4; i++) begin
        step(1'b1, rk[i], 1'b0, 1'b0);
        if (i < 3) for (int k = 0; k < gaps[g]; k++) step(1'b0, $urandom, 1'b0, 1'b0);
      end
      check("gap_key", keyOut, rk_key);
      rise_at = -1;
      for (int e = 1; e <= SETTLE + 3; e++) begin
        step(1'b0, $urandom, 1'b0, 1'b0);
        if (keysValid && rise_at < 0) rise_at = e;
      end
      check("gap_latency", KW'(rise_at), KW'(SETTLE));
    end

    // Random traffic with occasional reset (and abort when present).
    for (int c = 0; c < 400; c++) begin
      step(1'($urandom % 2), $urandom, ($urandom % 64) == 0, ($urandom % 16) == 0);
    end

`ifdef KEYLOAD_ABORT_EN
    step(1'b0, 32'h0, 1'b1, 1'b0);
    step(1'b1, 32'h11111111, 1'b0, 1'b0);
    step(1'b1, 32'h22222222, 1'b0, 1'b0);
    step(1'b1, 32'h33333333, 1'b0, 1'b1);
    for (int i = 0; i < 4; i++) step(1'b1, rk[i], 1'b0, 1'b0);
    check("abort_key", keyOut, rk_key);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
